// File: rtl/vx_mem_responder_pkg.sv
// Shared defaults and helpers for the memory responder.
package vx_mem_responder_pkg;

    localparam int DEF_DATA_SIZE      = 64;
    localparam int DEF_ADDR_WIDTH     = 26;
    localparam int DEF_TAG_WIDTH      = 8;
    localparam int DEF_NUM_LINES      = 1024;
    localparam int DEF_LATENCY        = 4;
    localparam int DEF_RSP_QUEUE_SIZE = 8;

    // Index width for a storage of n entries; never less than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_mem_responder_fifo.sv
// Response FIFO: registered storage, output valid whenever non-empty.
// The caller never pushes when full (credits cover every in-flight read).
module vx_mem_responder_fifo #(
    parameter int DATAW = 520,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATAW-1:0]         push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [DATAW-1:0]         data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATAW-1:0] store [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointer update; an extra wrap bit distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push) store[wr_ptr[AW-1:0]] <= push_data;
    end

    assign valid = (wr_ptr != rd_ptr);
    assign data  = store[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/vx_mem_responder.sv
// Memory-side responder: line storage with byte-enabled writes, fixed-latency
// tagged read responses, credit throttling so responses are never dropped.
module vx_mem_responder
    import vx_mem_responder_pkg::*;
#(
    parameter int DATA_SIZE      = DEF_DATA_SIZE,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int TAG_WIDTH      = DEF_TAG_WIDTH,
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int LATENCY        = DEF_LATENCY,
    parameter int RSP_QUEUE_SIZE = DEF_RSP_QUEUE_SIZE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic                     req_rw,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [DATA_SIZE-1:0]     req_byteen,
    input  logic [8*DATA_SIZE-1:0]   req_data,
    input  logic [TAG_WIDTH-1:0]     req_tag,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [8*DATA_SIZE-1:0]   rsp_data,
    output logic [TAG_WIDTH-1:0]     rsp_tag,
    input  logic                     rsp_ready
);
    localparam int IDX_W  = idx_bits(NUM_LINES);
    localparam int LINE_W = 8 * DATA_SIZE;
    localparam int RSPW   = LINE_W + TAG_WIDTH;
    localparam int CRD_W  = $clog2(RSP_QUEUE_SIZE + 1);
    // One pipeline slot is absorbed by the FIFO's own output register.
    localparam int STAGES = LATENCY - 1;

    logic [LINE_W-1:0]  mem [NUM_LINES];
    logic [IDX_W-1:0]   idx;
    logic [CRD_W-1:0]   credit_cnt;
    logic [CRD_W-1:0]   inflight;
    logic               wr_fire;
    logic               rd_fire;
    logic               pop;
    logic               push;
    logic [RSPW-1:0]    push_data;
    logic               fifo_valid;
    logic [RSPW-1:0]    fifo_data;
    logic [CRD_W-1:0]   fifo_count;

    // Upper address bits alias onto the same lines.
    assign idx = req_addr[IDX_W-1:0];

    generate
        if (ADDR_WIDTH > IDX_W) begin : g_alias
            logic unused_addr;
            assign unused_addr = ^req_addr[ADDR_WIDTH-1:IDX_W];
        end
    endgenerate

    assign req_ready = (credit_cnt != '0) && !reset;
    assign wr_fire   = req_valid && req_ready && req_rw;
    assign rd_fire   = req_valid && req_ready && !req_rw;
    assign rsp_valid = fifo_valid && !reset;
    assign pop       = rsp_valid && rsp_ready;

    // Byte-enabled line write, visible to reads from the next cycle on.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < DATA_SIZE; b++) begin
                if (req_byteen[b]) mem[idx][b*8 +: 8] <= req_data[b*8 +: 8];
            end
        end
    end

    generate
        if (STAGES == 0) begin : g_direct
            assign push      = rd_fire;
            assign push_data = {mem[idx], req_tag};
            assign inflight  = '0;
        end else begin : g_pipe
            logic [STAGES-1:0] pipe_v;
            logic [RSPW-1:0]   pipe_d [STAGES];

            // Valid bits of the read pipeline; reset drops in-flight reads.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pipe_v <= '0;
                end else begin
                    pipe_v[0] <= rd_fire;
                    for (int i = 1; i < STAGES; i++) pipe_v[i] <= pipe_v[i-1];
                end
            end

            // Payload of the read pipeline, qualified by pipe_v.
            always_ff @(posedge clk) begin
                pipe_d[0] <= {mem[idx], req_tag};
                for (int i = 1; i < STAGES; i++) pipe_d[i] <= pipe_d[i-1];
            end

            assign push      = pipe_v[STAGES-1];
            assign push_data = pipe_d[STAGES-1];
            assign inflight  = CRD_W'($countones(pipe_v));
        end
    endgenerate

    vx_mem_responder_fifo #(
        .DATAW (RSPW),
        .DEPTH (RSP_QUEUE_SIZE)
    ) rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .valid     (fifo_valid),
        .data      (fifo_data),
        .count     (fifo_count)
    );

    assign rsp_data = fifo_data[RSPW-1:TAG_WIDTH];
    assign rsp_tag  = fifo_data[TAG_WIDTH-1:0];

    // Credits: one per FIFO slot, taken on read accept, returned on pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_cnt <= CRD_W'(RSP_QUEUE_SIZE);
        end else begin
            case ({rd_fire, pop})
                2'b10:   credit_cnt <= credit_cnt - 1'b1;
                2'b01:   credit_cnt <= credit_cnt + 1'b1;
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    // Queued plus in-flight reads must always fit in the response FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (int'(fifo_count) + int'(inflight) <= RSP_QUEUE_SIZE);
        end
    end

endmodule
